multi_cycle_controller: RTL and testbench
=========================================

// Module: multi_cycle_controller
// PURPOSE
//  Sequencing FSM for the multi-cycle RV32 datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Drives per-cycle enables and mux selects for PC, IR, memory, register file and ALU. Supports R-type, LW, SW, BEQ.
//  Sits beside the shared datapath. Reads the IR opcode, the ALU zero flag and the memory ready handshake.
// PARAMETERS
//  INSTRUCTION_LEN  32  IR width
//  OPCODE_W         7   opcode field width, instruction[OPCODE_W-1:0]
//  COUNT_W          32  retired-instruction counter width
// PORTS
//  clk            in   1                single clock, all state on rising edge
//  reset          in   1                synchronous, active-high
//  instruction    in   INSTRUCTION_LEN  IR contents; valid from DECODE onward
//  zero           in   1                ALU zero flag
//  mem_ready      in   1                memory completes the current read/write this cycle
//  pc_write       out  1                PC load enable
//  ir_write       out  1                IR load enable
//  i_or_d         out  1                memory address sel: 0=PC, 1=ALUOut
//  mem_read       out  1                memory read strobe
//  mem_write      out  1                memory write strobe
//  reg_write      out  1                register-file write enable
//  mem_to_reg     out  1                write-back sel: 0=ALUOut, 1=MDR
//  alu_src_a      out  1                0=PC, 1=rs1
//  alu_src_b      out  2                00=rs2, 01=const 4, 10=imm
//  alu_op         out  2                00=add, 01=sub(compare), 10=funct-decoded
//  pc_source      out  1                0=ALU result, 1=ALUOut (branch target)
//  illegal        out  1                sticky unsupported-opcode flag
//  state          out  4                current state, debug
//  instr_retired  out  COUNT_W          count of completed instructions
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, LOAD_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, TRAP=9.
//  Opcodes: R=51, LOAD=3, STORE=35, BEQ=99.
//  Output encoding: Moore outputs decoded from the registered state, except where gated by mem_ready or zero.
//    Any output not listed for a state is 0.
//  FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
//    ir_write=pc_write=mem_ready. Hold in FETCH while !mem_ready. Go to DECODE on mem_ready.
//  DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
//    LOAD/STORE->MEM_ADDR, R->R_EXEC, BEQ->BRANCH, any other opcode->TRAP.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: LOAD->MEM_RD, STORE->MEM_WR.
//  MEM_RD: mem_read=1, i_or_d=1. Hold while !mem_ready, then LOAD_WB.
//  LOAD_WB: reg_write=1, mem_to_reg=1. Next FETCH.
//  MEM_WR: mem_write=1, i_or_d=1. Hold while !mem_ready, then FETCH.
//  R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
//  R_WB: reg_write=1, mem_to_reg=0. Next FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=1, pc_write=zero. Next FETCH.
//  TRAP: all enables 0, illegal=1. Stays in TRAP until reset.
//  Latency with mem_ready tied 1: R=4, LW=5, SW=4, BEQ=3 cycles.
//    Each stall cycle (mem_ready=0) adds exactly one cycle.
//  mem_read/mem_write hold steady for the whole stall. No strobe is ever asserted for a single partial cycle.
//  instr_retired increments by 1 on every transition into FETCH from any state except FETCH. Wraps modulo 2^COUNT_W.
//  Reset (sync, mid-instruction included): next edge forces state=FETCH, instr_retired=0, illegal=0.
//    While reset=1, every enable and strobe output is forced to 0.
//    In-flight memory strobes are dropped and no register or PC write is issued.
//  Undefined state encodings (10-15) go to FETCH on the next edge.
// STRUCTURE
//  Package riscv_mc_pkg: opcode localparams, state encodings, alu_op and alu_src_b encodings, shared with datapath/ALU control.
//  Sub-module mc_output_decode: purely combinational map state, mem_ready, zero, reset -> control outputs.
//  The top module keeps the state register, next-state logic, illegal flag and counter.
// TESTING
//  add (opcode 51), mem_ready=1: states 0,1,6,7,0. reg_write=1 only in cycle 4. instr_retired 0->1.
//  lw (opcode 3) with mem_ready low 2 cycles in MEM_RD: states 0,1,2,3,3,3,4,0.
//    mem_read=1, i_or_d=1 held 3 cycles. mem_to_reg=1 in LOAD_WB.
//  beq (opcode 99): zero=1 -> pc_write=1, pc_source=1 in BRANCH. zero=0 -> pc_write=0. Both return to FETCH.
//  opcode 7'h7F -> TRAP, illegal=1, counter frozen. Assert reset 1 cycle -> FETCH, illegal=0, count=0.
//  reset asserted during MEM_WR stall: mem_write=0 that cycle. FETCH next cycle. No reg_write/pc_write issued.
//  Fetch stall: mem_ready=0 for 4 cycles in FETCH -> ir_write=pc_write=0 throughout, then 1 for one cycle.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32 controller: opcodes, FSM state
// encodings, ALU select encodings and the bundled control word.
package riscv_mc_pkg;

    // Width of the opcode field, instruction[OPC_W-1:0]
    localparam int unsigned OPC_W = 7;

    // Supported RV32 major opcodes
    localparam logic [OPC_W-1:0] OPC_R     = 7'd51;
    localparam logic [OPC_W-1:0] OPC_LOAD  = 7'd3;
    localparam logic [OPC_W-1:0] OPC_STORE = 7'd35;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 7'd99;

    // FSM states; encodings 10-15 are unused and recover to S_FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_LOAD_WB  = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_TRAP     = 4'd9
    } state_e;

    // ALU operation select seen by the ALU control block
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    // ALU B-operand select
    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_FOUR = 2'b01,
        SRC_B_IMM  = 2'b10
    } alu_src_b_e;

    // Every datapath control driven by the controller in one cycle
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        logic       pc_source;
    } ctrl_t;

    // True for opcodes that go through the address-calculation state
    function automatic logic is_mem_opcode(input logic [OPC_W-1:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle. The controller uses the master view (reads
// IR/zero/mem_ready, drives controls); the datapath uses the slave view.
interface multi_cycle_controller_if #(
    parameter int unsigned INSTRUCTION_LEN = 32,
    parameter int unsigned COUNT_W         = 32
);
    logic [INSTRUCTION_LEN-1:0] instruction;
    logic                       zero;
    logic                       mem_ready;

    logic                       pc_write;
    logic                       ir_write;
    logic                       i_or_d;
    logic                       mem_read;
    logic                       mem_write;
    logic                       reg_write;
    logic                       mem_to_reg;
    logic                       alu_src_a;
    logic [1:0]                 alu_src_b;
    logic [1:0]                 alu_op;
    logic                       pc_source;
    logic                       illegal;
    logic [3:0]                 state;
    logic [COUNT_W-1:0]         instr_retired;

    modport master (
        input  instruction, zero, mem_ready,
        output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal, state, instr_retired
    );

    modport slave (
        output instruction, zero, mem_ready,
        input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal, state, instr_retired
    );
endinterface

// File: rtl/multi_cycle_controller_output_decode.sv
// Combinational control decode: maps the registered FSM state (gated by
// mem_ready, zero and reset) onto the datapath control word.
module mc_output_decode
    import riscv_mc_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    input  logic   zero,
    input  logic   reset,
    output ctrl_t  ctrl
);

    // Moore decode per state; reset forces every enable and select low
    always_comb begin
        ctrl = '0;
        if (reset) begin
            ctrl = '0;
        end else begin
            case (state)
                S_FETCH: begin
                    // IR and PC only load in the cycle memory actually returns
                    ctrl.mem_read  = 1'b1;
                    ctrl.i_or_d    = 1'b0;
                    ctrl.alu_src_a = 1'b0;
                    ctrl.alu_src_b = SRC_B_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    // Speculative branch target PC+imm lands in ALUOut
                    ctrl.alu_src_a = 1'b0;
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_RD: begin
                    // Held for the whole stall so the strobe never breaks
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                S_LOAD_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRC_B_RS2;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b0;
                end
                S_BRANCH: begin
                    // Compare rs1-rs2; take ALUOut target only when equal
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRC_B_RS2;
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.pc_source = 1'b1;
                    ctrl.pc_write  = zero;
                end
                S_TRAP: begin
                    ctrl = '0;
                end
                default: begin
                    ctrl = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32 sequencing controller (R-type, LW, SW, BEQ). Holds the
// state register, next-state logic, sticky illegal flag and retire counter;
// control outputs come from mc_output_decode.
module multi_cycle_controller
    import riscv_mc_pkg::*;
#(
    parameter int unsigned INSTRUCTION_LEN = 32,
    parameter int unsigned OPCODE_W        = OPC_W,
    parameter int unsigned COUNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    multi_cycle_controller_if.master bus
);

    localparam logic [COUNT_W-1:0] RETIRE_INC = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_e               state_r;
    logic                 illegal_r;
    logic [COUNT_W-1:0]   retired_r;
    logic [OPCODE_W-1:0]  opcode_s;
    ctrl_t                ctrl_s;

    assign opcode_s = bus.instruction[OPCODE_W-1:0];

    // FSM: state transitions, sticky illegal flag and retire count
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_FETCH;
            illegal_r <= 1'b0;
            retired_r <= '0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        state_r <= S_DECODE;
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    if (is_mem_opcode(opcode_s)) begin
                        state_r <= S_MEM_ADDR;
                    end else if (opcode_s == OPC_R) begin
                        state_r <= S_R_EXEC;
                    end else if (opcode_s == OPC_BEQ) begin
                        state_r <= S_BRANCH;
                    end else begin
                        state_r   <= S_TRAP;
                        illegal_r <= 1'b1;
                    end
                end
                S_MEM_ADDR: begin
                    // IR is stable, so only LOAD/STORE can be seen here
                    if (opcode_s == OPC_LOAD) begin
                        state_r <= S_MEM_RD;
                    end else if (opcode_s == OPC_STORE) begin
                        state_r <= S_MEM_WR;
                    end else begin
                        state_r   <= S_TRAP;
                        illegal_r <= 1'b1;
                    end
                end
                S_MEM_RD: begin
                    if (bus.mem_ready) begin
                        state_r <= S_LOAD_WB;
                    end else begin
                        state_r <= S_MEM_RD;
                    end
                end
                S_LOAD_WB: begin
                    state_r   <= S_FETCH;
                    retired_r <= retired_r + RETIRE_INC;
                end
                S_MEM_WR: begin
                    if (bus.mem_ready) begin
                        state_r   <= S_FETCH;
                        retired_r <= retired_r + RETIRE_INC;
                    end else begin
                        state_r <= S_MEM_WR;
                    end
                end
                S_R_EXEC: begin
                    state_r <= S_R_WB;
                end
                S_R_WB: begin
                    state_r   <= S_FETCH;
                    retired_r <= retired_r + RETIRE_INC;
                end
                S_BRANCH: begin
                    state_r   <= S_FETCH;
                    retired_r <= retired_r + RETIRE_INC;
                end
                S_TRAP: begin
                    state_r <= S_TRAP;
                end
                default: begin
                    // Corrupted encoding: recover; entering FETCH counts
                    state_r   <= S_FETCH;
                    retired_r <= retired_r + RETIRE_INC;
                end
            endcase
        end
    end

    mc_output_decode u_output_decode (
        .state     (state_r),
        .mem_ready (bus.mem_ready),
        .zero      (bus.zero),
        .reset     (reset),
        .ctrl      (ctrl_s)
    );

    assign bus.pc_write      = ctrl_s.pc_write;
    assign bus.ir_write      = ctrl_s.ir_write;
    assign bus.i_or_d        = ctrl_s.i_or_d;
    assign bus.mem_read      = ctrl_s.mem_read;
    assign bus.mem_write     = ctrl_s.mem_write;
    assign bus.reg_write     = ctrl_s.reg_write;
    assign bus.mem_to_reg    = ctrl_s.mem_to_reg;
    assign bus.alu_src_a     = ctrl_s.alu_src_a;
    assign bus.alu_src_b     = ctrl_s.alu_src_b;
    assign bus.alu_op        = ctrl_s.alu_op;
    assign bus.pc_source     = ctrl_s.pc_source;
    assign bus.illegal       = illegal_r;
    assign bus.state         = state_r;
    assign bus.instr_retired = retired_r;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller. Each cycle's expected
// {state, controls, illegal} word is queued when stimulus is applied and
// popped and compared at the following falling edge.
module tb_multi_cycle_controller;
    import riscv_mc_pkg::*;

    // Expected word: {state[3:0], pc_write, ir_write, i_or_d, mem_read,
    //   mem_write, reg_write, mem_to_reg, alu_src_a, alu_src_b[1:0],
    //   alu_op[1:0], pc_source, illegal}
    localparam logic [17:0] E_FETCH_RDY   = {4'd0, 8'b11010000, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_FETCH_STALL = {4'd0, 8'b00010000, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_DECODE      = {4'd1, 8'b00000000, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_MEM_ADDR    = {4'd2, 8'b00000001, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_MEM_RD      = {4'd3, 8'b00110000, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_LOAD_WB     = {4'd4, 8'b00000110, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_MEM_WR      = {4'd5, 8'b00101000, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_R_EXEC      = {4'd6, 8'b00000001, 2'b00, 2'b10, 1'b0, 1'b0};
    localparam logic [17:0] E_R_WB        = {4'd7, 8'b00000100, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_BR_Z        = {4'd8, 8'b10000001, 2'b00, 2'b01, 1'b1, 1'b0};
    localparam logic [17:0] E_BR_NZ       = {4'd8, 8'b00000001, 2'b00, 2'b01, 1'b1, 1'b0};
    localparam logic [17:0] E_TRAP        = {4'd9, 8'b00000000, 2'b00, 2'b00, 1'b0, 1'b1};
    localparam logic [17:0] E_RST_FETCH   = {4'd0, 8'b00000000, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_RST_MEM_WR  = {4'd5, 8'b00000000, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_RST_TRAP    = {4'd9, 8'b00000000, 2'b00, 2'b00, 1'b0, 1'b1};
    localparam logic [6:0]  OPC_BAD       = 7'h7F;

    typedef struct packed {
        logic        rst;
        logic [6:0]  opc;
        logic        rdy;
        logic        z;
        logic [17:0] exp;
    } stim_t;

    logic        clk;
    logic        reset;
    logic [17:0] obs_s;
    logic [17:0] sb_q[$];
    int          n_checks;
    int          n_pass;
    logic [31:0] exp_retired;

    multi_cycle_controller_if #(.INSTRUCTION_LEN(32), .COUNT_W(32)) bus ();

    multi_cycle_controller #(
        .INSTRUCTION_LEN (32),
        .OPCODE_W        (7),
        .COUNT_W         (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign obs_s = {bus.state, bus.pc_write, bus.ir_write, bus.i_or_d, bus.mem_read,
                    bus.mem_write, bus.reg_write, bus.mem_to_reg, bus.alu_src_a,
                    bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic rst, input logic [6:0] opc, input logic rdy,
                                 input logic z, input logic [17:0] exp);
        stim_t s;
        s.rst = rst; s.opc = opc; s.rdy = rdy; s.z = z; s.exp = exp;
        return s;
    endfunction

    // Drive one cycle's inputs (upper IR bits random) and queue its expectation
    task automatic apply(input stim_t s);
        logic [31:0] instr;
        instr = $urandom();
        instr[6:0] = s.opc;
        reset = s.rst;
        bus.instruction = instr;
        bus.mem_ready = s.rdy;
        bus.zero = s.z;
        sb_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        logic [17:0] exp_w;
        reset = 1'b1;
        bus.instruction = 32'h0;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(E_RST_FETCH);
        @(negedge clk);
        exp_w = sb_q.pop_front();
        n_checks++;
        if (obs_s !== exp_w) $display("FAIL reset_outputs got %05h exp %05h", obs_s, exp_w);
        else n_pass++;
        exp_retired = 32'd0;
        n_checks++;
        if (bus.instr_retired !== exp_retired)
            $display("FAIL reset_count got %0d exp %0d", bus.instr_retired, exp_retired);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        stim_t st[$];
        logic [17:0] exp_w;
        st.push_back(mk(1'b0, OPC_R, 1'b1, 1'b0, E_FETCH_RDY));
        st.push_back(mk(1'b0, OPC_R, 1'b1, 1'b1, E_DECODE));
        st.push_back(mk(1'b0, OPC_R, 1'b1, 1'b0, E_R_EXEC));
        st.push_back(mk(1'b0, OPC_R, 1'b1, 1'b1, E_R_WB));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            exp_w = sb_q.pop_front();
            n_checks++;
            if (obs_s !== exp_w) $display("FAIL add[%0d] got %05h exp %05h", i, obs_s, exp_w);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        exp_retired = exp_retired + 32'd1;
        n_checks++;
        if (bus.instr_retired !== exp_retired || bus.state !== 4'd0)
            $display("FAIL add_retire got cnt %0d st %0d exp cnt %0d st 0",
                     bus.instr_retired, bus.state, exp_retired);
        else n_pass++;
    endtask

    task automatic test_lw_stall();
        stim_t st[$];
        logic [17:0] exp_w;
        st.push_back(mk(1'b0, OPC_LOAD, 1'b1, 1'b0, E_FETCH_RDY));
        st.push_back(mk(1'b0, OPC_LOAD, 1'b0, 1'b0, E_DECODE));
        st.push_back(mk(1'b0, OPC_LOAD, 1'b0, 1'b1, E_MEM_ADDR));
        st.push_back(mk(1'b0, OPC_LOAD, 1'b0, 1'b0, E_MEM_RD));
        st.push_back(mk(1'b0, OPC_LOAD, 1'b0, 1'b1, E_MEM_RD));
        st.push_back(mk(1'b0, OPC_LOAD, 1'b1, 1'b0, E_MEM_RD));
        st.push_back(mk(1'b0, OPC_LOAD, 1'b0, 1'b0, E_LOAD_WB));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            exp_w = sb_q.pop_front();
            n_checks++;
            if (obs_s !== exp_w) $display("FAIL lw_stall[%0d] got %05h exp %05h", i, obs_s, exp_w);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        exp_retired = exp_retired + 32'd1;
        n_checks++;
        if (bus.instr_retired !== exp_retired || bus.state !== 4'd0)
            $display("FAIL lw_retire got cnt %0d st %0d exp cnt %0d st 0",
                     bus.instr_retired, bus.state, exp_retired);
        else n_pass++;
    endtask

    task automatic test_sw_beq();
        stim_t st[$];
        logic [17:0] exp_w;
        st.push_back(mk(1'b0, OPC_STORE, 1'b1, 1'b0, E_FETCH_RDY));
        st.push_back(mk(1'b0, OPC_STORE, 1'b1, 1'b0, E_DECODE));
        st.push_back(mk(1'b0, OPC_STORE, 1'b1, 1'b0, E_MEM_ADDR));
        st.push_back(mk(1'b0, OPC_STORE, 1'b1, 1'b0, E_MEM_WR));
        st.push_back(mk(1'b0, OPC_BEQ,   1'b1, 1'b0, E_FETCH_RDY));
        st.push_back(mk(1'b0, OPC_BEQ,   1'b1, 1'b0, E_DECODE));
        st.push_back(mk(1'b0, OPC_BEQ,   1'b1, 1'b1, E_BR_Z));
        st.push_back(mk(1'b0, OPC_BEQ,   1'b1, 1'b1, E_FETCH_RDY));
        st.push_back(mk(1'b0, OPC_BEQ,   1'b1, 1'b1, E_DECODE));
        st.push_back(mk(1'b0, OPC_BEQ,   1'b1, 1'b0, E_BR_NZ));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            exp_w = sb_q.pop_front();
            n_checks++;
            if (obs_s !== exp_w) $display("FAIL sw_beq[%0d] got %05h exp %05h", i, obs_s, exp_w);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        exp_retired = exp_retired + 32'd3;
        n_checks++;
        if (bus.instr_retired !== exp_retired || bus.state !== 4'd0)
            $display("FAIL sw_beq_retire got cnt %0d st %0d exp cnt %0d st 0",
                     bus.instr_retired, bus.state, exp_retired);
        else n_pass++;
    endtask

    task automatic test_fetch_stall();
        stim_t st[$];
        logic [17:0] exp_w;
        repeat (4) st.push_back(mk(1'b0, OPC_R, 1'b0, 1'b0, E_FETCH_STALL));
        st.push_back(mk(1'b0, OPC_R, 1'b1, 1'b0, E_FETCH_RDY));
        st.push_back(mk(1'b0, OPC_R, 1'b0, 1'b0, E_DECODE));
        st.push_back(mk(1'b0, OPC_R, 1'b0, 1'b0, E_R_EXEC));
        st.push_back(mk(1'b0, OPC_R, 1'b0, 1'b0, E_R_WB));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            exp_w = sb_q.pop_front();
            n_checks++;
            if (obs_s !== exp_w) $display("FAIL fetch_stall[%0d] got %05h exp %05h", i, obs_s, exp_w);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        exp_retired = exp_retired + 32'd1;
        n_checks++;
        if (bus.instr_retired !== exp_retired)
            $display("FAIL fetch_stall_retire got %0d exp %0d", bus.instr_retired, exp_retired);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        logic [17:0] exp_w;
        logic        z;
        for (int k = 0; k < 10; k++) begin
            z = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin
                    st.push_back(mk(1'b0, OPC_R, 1'b1, ~z, E_FETCH_RDY));
                    st.push_back(mk(1'b0, OPC_R, 1'b1, z, E_DECODE));
                    st.push_back(mk(1'b0, OPC_R, 1'b1, ~z, E_R_EXEC));
                    st.push_back(mk(1'b0, OPC_R, 1'b1, z, E_R_WB));
                end
                1: begin
                    st.push_back(mk(1'b0, OPC_LOAD, 1'b1, z, E_FETCH_RDY));
                    st.push_back(mk(1'b0, OPC_LOAD, 1'b1, z, E_DECODE));
                    st.push_back(mk(1'b0, OPC_LOAD, 1'b1, z, E_MEM_ADDR));
                    st.push_back(mk(1'b0, OPC_LOAD, 1'b1, z, E_MEM_RD));
                    st.push_back(mk(1'b0, OPC_LOAD, 1'b1, z, E_LOAD_WB));
                end
                2: begin
                    st.push_back(mk(1'b0, OPC_STORE, 1'b1, z, E_FETCH_RDY));
                    st.push_back(mk(1'b0, OPC_STORE, 1'b1, z, E_DECODE));
                    st.push_back(mk(1'b0, OPC_STORE, 1'b1, z, E_MEM_ADDR));
                    st.push_back(mk(1'b0, OPC_STORE, 1'b1, z, E_MEM_WR));
                end
                default: begin
                    st.push_back(mk(1'b0, OPC_BEQ, 1'b1, ~z, E_FETCH_RDY));
                    st.push_back(mk(1'b0, OPC_BEQ, 1'b1, ~z, E_DECODE));
                    st.push_back(mk(1'b0, OPC_BEQ, 1'b1, z, z ? E_BR_Z : E_BR_NZ));
                end
            endcase
        end
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            exp_w = sb_q.pop_front();
            n_checks++;
            if (obs_s !== exp_w) $display("FAIL b2b[%0d] got %05h exp %05h", i, obs_s, exp_w);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        exp_retired = exp_retired + 32'd10;
        n_checks++;
        if (bus.instr_retired !== exp_retired)
            $display("FAIL b2b_retire got %0d exp %0d", bus.instr_retired, exp_retired);
        else n_pass++;
    endtask

    task automatic test_trap();
        stim_t st[$];
        logic [17:0] exp_w;
        st.push_back(mk(1'b0, OPC_BAD, 1'b1, 1'b0, E_FETCH_RDY));
        st.push_back(mk(1'b0, OPC_BAD, 1'b1, 1'b0, E_DECODE));
        st.push_back(mk(1'b0, OPC_BAD, 1'b1, 1'b1, E_TRAP));
        st.push_back(mk(1'b0, OPC_R,   1'b1, 1'b1, E_TRAP));
        st.push_back(mk(1'b1, OPC_R,   1'b1, 1'b1, E_RST_TRAP));
        st.push_back(mk(1'b0, OPC_R,   1'b0, 1'b0, E_FETCH_STALL));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            exp_w = sb_q.pop_front();
            n_checks++;
            if (obs_s !== exp_w) $display("FAIL trap[%0d] got %05h exp %05h", i, obs_s, exp_w);
            else n_pass++;
            if (i == 3) begin
                n_checks++;
                if (bus.instr_retired !== exp_retired)
                    $display("FAIL trap_frozen got %0d exp %0d", bus.instr_retired, exp_retired);
                else n_pass++;
                exp_retired = 32'd0;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (bus.instr_retired !== exp_retired)
            $display("FAIL trap_reset_count got %0d exp %0d", bus.instr_retired, exp_retired);
        else n_pass++;
    endtask

    task automatic test_reset_mid_store();
        stim_t st[$];
        logic [17:0] exp_w;
        st.push_back(mk(1'b0, OPC_R,     1'b1, 1'b0, E_FETCH_RDY));
        st.push_back(mk(1'b0, OPC_R,     1'b1, 1'b0, E_DECODE));
        st.push_back(mk(1'b0, OPC_R,     1'b1, 1'b0, E_R_EXEC));
        st.push_back(mk(1'b0, OPC_R,     1'b1, 1'b0, E_R_WB));
        st.push_back(mk(1'b0, OPC_STORE, 1'b1, 1'b0, E_FETCH_RDY));
        st.push_back(mk(1'b0, OPC_STORE, 1'b1, 1'b0, E_DECODE));
        st.push_back(mk(1'b0, OPC_STORE, 1'b0, 1'b0, E_MEM_ADDR));
        st.push_back(mk(1'b0, OPC_STORE, 1'b0, 1'b0, E_MEM_WR));
        st.push_back(mk(1'b1, OPC_STORE, 1'b0, 1'b1, E_RST_MEM_WR));
        st.push_back(mk(1'b0, OPC_STORE, 1'b0, 1'b0, E_FETCH_STALL));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            exp_w = sb_q.pop_front();
            n_checks++;
            if (obs_s !== exp_w) $display("FAIL rst_mid_store[%0d] got %05h exp %05h", i, obs_s, exp_w);
            else n_pass++;
            if (i == 4) begin
                exp_retired = exp_retired + 32'd1;
                n_checks++;
                if (bus.instr_retired !== exp_retired)
                    $display("FAIL pre_reset_count got %0d exp %0d", bus.instr_retired, exp_retired);
                else n_pass++;
            end
            @(posedge clk);
            #1;
        end
        exp_retired = 32'd0;
        n_checks++;
        if (bus.instr_retired !== exp_retired || bus.illegal !== 1'b0)
            $display("FAIL rst_mid_store_count got cnt %0d ill %0b exp cnt 0 ill 0",
                     bus.instr_retired, bus.illegal);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        exp_retired = 32'd0;
        reset = 1'b1;
        bus.instruction = 32'h0;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        test_reset();
        test_add();
        test_lw_stall();
        test_sw_beq();
        test_fetch_stall();
        test_back_to_back();
        test_trap();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
